// File: rtl/uart_rx_apb.sv
// -----------------------------------------------------------------------------
// uart_rx_apb
//   APB slave UART receiver (8N1). The serial input is synchronised, and then
//   decoded by a bit-timer FSM. Received bytes are buffered in a small circular
//   FIFO that cores read over APB. An interrupt level is held while data is
//   pending.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   S_PADDR    register select: 0 DATA, 1 STATUS, 2 COUNT, 3 reserved
//   S_PWRITE   APB write strobe
//   S_PSELx    APB select
//   S_PENABLE  APB enable
//   S_PWDATA   APB write data (STATUS b2/b3 are write-1-to-clear)
//   S_PRDATA   APB read data, combinational, 0 when not enabled
//   S_PREADY   S_PSELx & S_PENABLE (zero wait states)
//   rx_wire    asynchronous serial input, idle high
//   out        interrupt level, high while the FIFO is non-empty
//   int_data   FIFO head byte, zero-extended, 0 when empty
// -----------------------------------------------------------------------------
module uart_rx_apb #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    input  logic                  rx_wire,
    output logic                  out,
    output logic [DATA_WIDTH-1:0] int_data
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int CW           = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------ sync
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_wire;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------- APB decode
    logic w_en;
    logic w_rd;
    logic w_wr_status;
    logic w_ovr_clr;
    logic w_fe_clr;

    assign w_en        = S_PSELx & S_PENABLE;
    assign S_PREADY    = w_en;
    assign w_rd        = w_en & ~S_PWRITE;
    assign w_wr_status = w_en & S_PWRITE & (S_PADDR == 2'd1);
    assign w_ovr_clr   = w_wr_status & S_PWDATA[2];
    assign w_fe_clr    = w_wr_status & S_PWDATA[3];

    // Only b2/b3 of the write data have any effect.
    logic w_unused;
    assign w_unused = ^{S_PWDATA[DATA_WIDTH-1:4], S_PWDATA[1:0]};

    // ---------------------------------------------------------- receiver FSM
    state_t      r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_armed;
    logic        r_frame_err;

    // r_armed blocks a new start detection after a framing error until the
    // line has been seen idle (high) again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            if (w_fe_clr)
                r_frame_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_timer <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_timer == T_HALF) begin
                        if (!r_rx_s) begin
                            r_timer   <= '0;
                            r_bit_idx <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_timer == T_FULL) begin
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_timer            <= '0;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7)
                            r_state <= ST_STOP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_timer == T_FULL) begin
                        // Set after the clear above, so a same-cycle error wins.
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_armed     <= 1'b0;
                        end
                        r_timer <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Good stop bit sampled this cycle: byte is offered to the FIFO.
    logic w_push_req;
    assign w_push_req = (r_state == ST_STOP) && (r_timer == T_FULL) && r_rx_s;

    // ------------------------------------------------------------------ FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;

    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic [7:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pop   = w_rd & (S_PADDR == 2'd0) & ~w_empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_ovr_clr)
                r_overrun <= 1'b0;
            if (w_push_req && w_full && !w_pop)
                r_overrun <= 1'b1;
        end
    end

    // --------------------------------------------------------------- outputs
    assign out = ~w_empty;

    always_comb begin
        int_data = '0;
        if (!w_empty)
            int_data[7:0] = w_head;
    end

    always_comb begin
        S_PRDATA = '0;
        if (w_rd) begin
            case (S_PADDR)
                2'd0: if (!w_empty) S_PRDATA[7:0] = w_head;
                2'd1: S_PRDATA[3:0] = {r_frame_err, r_overrun, w_full, ~w_empty};
                2'd2: S_PRDATA[CW-1:0] = r_count;
                default: S_PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_apb.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_apb
//   Directed plus randomized bench for uart_rx_apb. Serial frames are driven
//   bit by bit; expected register contents come from a queue-based model of
//   the receive FIFO and its two sticky flags.
// -----------------------------------------------------------------------------
module tb_uart_rx_apb;

    localparam int CLK_HZ    = 160;
    localparam int BAUD      = 10;
    localparam int DEPTH     = 8;
    localparam int DW        = 16;
    localparam int CPB       = CLK_HZ / BAUD;
    // Negedge index (0 = start-bit falling edge) just before the posedge that
    // samples the stop bit: 2 sync stages, half a bit, then nine full bits.
    localparam int STOP_EDGE = 2 + CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          rx_wire;
    logic          out_irq;
    logic [DW-1:0] int_data;

    always #5 clk = ~clk;

    uart_rx_apb #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .S_PADDR  (paddr),
        .S_PWRITE (pwrite),
        .S_PSELx  (psel),
        .S_PENABLE(penable),
        .S_PWDATA (pwdata),
        .S_PRDATA (prdata),
        .S_PREADY (pready),
        .rx_wire  (rx_wire),
        .out      (out_irq),
        .int_data (int_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_fe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {28'd0, m_fe, m_ovr, (q.size() == DEPTH), (q.size() != 0)};
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic stop_bit);
        if (!stop_bit)
            m_fe = 1'b1;
        else if (q.size() == DEPTH)
            m_ovr = 1'b1;
        else
            q.push_back(d);
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        psel = 1'b1; paddr = a; pwrite = 1'b0; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        psel = 1'b1; paddr = a; pwrite = 1'b1; pwdata = d; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic status_write(input logic [DW-1:0] d);
        apb_write(2'd1, d);
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_fe  = 1'b0;
    endtask

    task automatic check_data(input string tag);
        logic [DW-1:0] v;
        logic [31:0]   e;
        apb_read(2'd0, v);
        e = (q.size() != 0) ? {24'd0, q.pop_front()} : 32'd0;
        chk(tag, v, e);
    endtask

    task automatic check_count(input string tag);
        logic [DW-1:0] v;
        apb_read(2'd2, v);
        chk(tag, v, q.size());
    endtask

    task automatic check_status(input string tag);
        logic [DW-1:0] v;
        apb_read(2'd1, v);
        chk(tag, v, exp_status());
    endtask

    task automatic check_irq(input string tag);
        chk({tag, "_out"}, out_irq, (q.size() != 0));
        chk({tag, "_int_data"}, int_data, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
    endtask

    // One 8N1 frame, one bit per CPB clocks. Optionally checks out around the
    // stop sample (empty FIFO only) or performs a DATA read whose enable phase
    // coincides with the stop-bit sample.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input bit rd_at_stop, input bit chk_lat,
                              output logic [DW-1:0] rd_val);
        logic [9:0] bits;
        bits   = {stop_bit, d, 1'b0};
        rd_val = '0;
        for (int n = 0; n < 10 * CPB; n++) begin
            @(negedge clk);
            if (n % CPB == 0)
                rx_wire = bits[n / CPB];
            if (chk_lat && n == STOP_EDGE)
                chk("latency_before_stop", out_irq, 1'b0);
            if (chk_lat && n == STOP_EDGE + 1)
                chk("latency_after_stop", out_irq, 1'b1);
            if (rd_at_stop) begin
                if (n == STOP_EDGE - 1) begin
                    psel = 1'b1; paddr = 2'd0; pwrite = 1'b0; penable = 1'b0;
                end
                if (n == STOP_EDGE) begin
                    penable = 1'b1;
                    #1 rd_val = prdata;
                end
                if (n == STOP_EDGE + 1) begin
                    psel = 1'b0; penable = 1'b0;
                end
            end
        end
        rx_wire = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit);
        logic [DW-1:0] unused_v;
        send_frame(d, stop_bit, 1'b0, 1'b0, unused_v);
        model_frame(d, stop_bit);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        logic [7:0]    d;
        logic          sb;
        logic [DW-1:0] e;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 2'd0; pwdata = '0; rx_wire = 1'b1;
        m_ovr = 1'b0; m_fe = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_out", out_irq, 1'b0);
        chk("rst_int_data", int_data, 32'd0);
        chk("rst_prdata_idle", prdata, 32'd0);
        chk("rst_pready_idle", pready, 1'b0);
        check_count("rst_count");
        check_status("rst_status");

        // 1: single byte, with interrupt latency around the stop sample
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, v);
        model_frame(8'hA5, 1'b1);
        check_irq("t1");
        check_count("t1_count");
        check_data("t1_data");
        check_irq("t1_after");
        check_count("t1_count_after");

        // 2: back-to-back bytes, ordering, read while empty
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        check_count("t2_count");
        for (int i = 0; i < 4; i++) check_data("t2_data");
        check_count("t2_count_empty");

        // 3: overrun
        for (int i = 0; i <= DEPTH; i++) send(8'(8'h10 + i), 1'b1);
        check_status("t3_status_full");
        check_count("t3_count_full");
        check_irq("t3");
        for (int i = 0; i < DEPTH; i++) check_data("t3_data");
        check_status("t3_status_drained");
        status_write(16'h0004);
        check_status("t3_status_cleared");

        // 4: start glitch, then a framing error
        @(negedge clk); rx_wire = 1'b0;
        repeat (4) @(negedge clk);
        rx_wire = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_count("t4_glitch_count");
        check_status("t4_glitch_status");
        send(8'h77, 1'b1);
        send(8'h5E, 1'b0);
        check_status("t4_fe_status");
        check_count("t4_fe_count");
        status_write(16'h0008);
        check_status("t4_fe_cleared");
        send(8'hC3, 1'b1);
        check_count("t4_recover_count");
        check_data("t4_d0");
        check_data("t4_d1");

        // 5: reset during bit 3 while holding two bytes
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        check_count("t5_count_before");
        @(negedge clk); rx_wire = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1; rx_wire = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete(); m_ovr = 1'b0; m_fe = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check_count("t5_count_after");
        check_irq("t5");
        check_status("t5_status");
        send(8'h3C, 1'b1);
        check_irq("t5_new");
        check_data("t5_new_data");

        // 6: full FIFO, pop coincident with a stop-bit push
        for (int i = 0; i < DEPTH; i++) send(8'(8'h80 + i), 1'b1);
        send_frame(8'h99, 1'b1, 1'b1, 1'b0, v);
        e = {8'd0, q.pop_front()};
        model_frame(8'h99, 1'b1);
        chk("t6_coincident_read", v, e);
        check_count("t6_count");
        check_status("t6_status");
        for (int i = 0; i < DEPTH; i++) check_data("t6_data");

        // 7: randomized traffic against the model
        for (int it = 0; it < 16; it++) begin
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 5) != 0);
            send(d, sb);
            check_count("rnd_count");
            check_status("rnd_status");
            check_irq("rnd");
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) check_data("rnd_data");
            end
            if ($urandom_range(0, 2) == 0)
                status_write(DW'($urandom_range(0, 65535)));
        end
        while (q.size() != 0) check_data("rnd_drain");
        check_data("rnd_empty_read");
        status_write(16'h000C);
        check_status("final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
